ps2_keyboard_decoder: RTL and testbench
=======================================

// Module: ps2_keyboard_decoder
// PURPOSE
//  Receives PS/2 keyboard frames and strips F0 (break) and E0 (extended) prefixes.
//  Presents the last make scancode on kbcode, held stable for the downstream
//  scancode->ASCII lookup, plus key-state flags and event strobes.
//  Sits between the board PS/2 pins and the ASCII/display logic.
// PARAMETERS
//  TIMEOUT_CYC  50000  clk cycles without a ps2_clk falling edge mid-frame before the frame is dropped
// PORTS
//  clk        in   1  system clock; only clock in the block
//  rst        in   1  synchronous reset, active-high
//  ps2_clk    in   1  raw PS/2 clock from pin, asynchronous
//  ps2_data   in   1  raw PS/2 data from pin, asynchronous
//  kbcode     out  8  last accepted make scancode, held until next make
//  is_ext     out  1  kbcode was preceded by E0
//  key_down   out  1  key in kbcode currently pressed
//  key_valid  out  1  one-cycle strobe: new make event on kbcode
//  key_rel    out  1  one-cycle strobe: break of the key in kbcode
//  frame_err  out  1  one-cycle strobe: frame rejected (start/stop/parity)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; bit counter=0. Reset mid-frame discards the partial frame.
//  Sync: ps2_clk and ps2_data each pass through 3 flops; a falling edge is sync[2:1]==2'b10.
//  Frame: 11 bits sampled on falling edges: start(0), D0..D7 LSB first, odd parity, stop(1).
//    Bit counter runs 0..10 and wraps to 0 after bit 10.
//  Accept: start==0, stop==1, ^{data,parity}==1 -> byte_rdy pulses on the cycle after the 11th edge.
//    Any check fails -> frame_err pulses in that same cycle; no byte_rdy; FSM unchanged.
//  Timeout: idle counter clears on each edge. It reaches TIMEOUT_CYC with bit counter !=0
//    -> counter to 0, frame dropped silently (no frame_err).
//  Decode FSM acts on byte_rdy; strobes are registered 1 cycle after byte_rdy.
//  States: IDLE, EXT, BRK, EXT_BRK.
//    IDLE    F0->BRK     E0->EXT      other: make, is_ext<=0
//    EXT     F0->EXT_BRK E0->EXT      other: make, is_ext<=1, ->IDLE
//    BRK/EXT_BRK  any byte b: break(b), ->IDLE
//  make(b): kbcode<=b, key_down<=1, key_valid pulse.
//  break(b): if b==kbcode and ext-match: key_down<=0, key_rel pulse; else ignored (kbcode unchanged).
//  key_valid and key_rel never both high. Total make latency: ~3 clk after 11th ps2_clk fall.
// CONFIGURATION
//  PS2_REPEAT_FILTER_EN defined:
//    make(b) with key_down==1 and b==kbcode (typematic repeat) -> no key_valid.
//  Undefined: every make, including repeats, pulses key_valid.
// STRUCTURE
//  Shared header ps2_defs.vh, localparams only:
//    PS2_BREAK=8'hF0, PS2_EXT=8'hE0
//    FSM state encodings IDLE/EXT/BRK/EXT_BRK (2 bits)
//  Sub-module ps2_frame_rx: synchronisers, edge detect, shift register, parity, timeout.
//    Outputs byte[7:0], byte_rdy, frame_err.
//  Top holds the decode FSM and output registers.
// TESTING  (bench drives ps2 at ~12.5 kHz)
//  1 frame 0x1C -> one key_valid, kbcode=0x1C, key_down=1, is_ext=0
//  2 then F0,1C -> key_rel once, key_down=0, kbcode stays 0x1C, no key_valid
//  3 E0,75 then E0,F0,75 -> kbcode=0x75, is_ext=1, key_valid once, then key_rel once
//  4 frame 0x1C with parity flipped -> frame_err one cycle, no key_valid, outputs unchanged
//  5 5 bits then stall >TIMEOUT_CYC, then frame 0x2D -> only 0x2D accepted, no frame_err
//  6 1C,1C,1C -> key_valid x1 with PS2_REPEAT_FILTER_EN, x3 without;
//    rst mid-frame -> all outputs 0 and next full frame decodes correctly

Source files
------------

// File: rtl/ps2_keyboard_decoder_pkg.sv
// Shared constants, decode-state encoding and receive-byte payload for the PS/2 keyboard decoder.
package ps2_keyboard_decoder_pkg;

  localparam logic [7:0]  PS2_BREAK  = 8'hF0;
  localparam logic [7:0]  PS2_EXT    = 8'hE0;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned SR_W       = FRAME_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       rdy;
    logic       err;
  } rx_byte_t;

  // sr holds start in [0], D0..D7 in [8:1], parity in [9]; stop is the live 11th bit
  function automatic logic frame_ok(input logic [SR_W-1:0] sr, input logic stop);
    return (sr[0] == 1'b0) && stop && (^sr[9:1]);
  endfunction

endpackage

// File: rtl/ps2_keyboard_decoder_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit shift/check, mid-frame timeout.
module ps2_keyboard_decoder_frame_rx
  import ps2_keyboard_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ps2_clk_i,
  input  logic     ps2_data_i,
  output rx_byte_t rx_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]           clk_sync_q;
  logic [2:0]           dat_sync_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  rx_byte_t             rx_q, rx_d;
  logic                 fall_c;

  assign fall_c = (clk_sync_q[2:1] == 2'b10);
  assign rx_o   = rx_q;

  // Bit sequencing, frame check on the 11th edge, and stall detection
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    idle_d    = idle_q;
    rx_d      = '{data: rx_q.data, rdy: 1'b0, err: 1'b0};
    if (fall_c) begin
      idle_d = '0;
      if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
        bit_cnt_d = '0;
        if (frame_ok(sr_q, dat_sync_q[1])) begin
          rx_d.data = sr_q[8:1];
          rx_d.rdy  = 1'b1;
        end else begin
          rx_d.err  = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        sr_d      = {dat_sync_q[1], sr_q[SR_W-1:1]};
      end
    end else if (bit_cnt_q != '0) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYC)) begin
        bit_cnt_d = '0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      idle_q     <= '0;
      rx_q       <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data_i};
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      idle_q     <= idle_d;
      rx_q       <= rx_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard decoder top: strips E0/F0 prefixes and holds the last make code with key state.
// Define PS2_REPEAT_FILTER_EN to suppress key_valid on typematic repeats of the held key.
module ps2_keyboard_decoder
  import ps2_keyboard_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbcode,
  output logic       is_ext,
  output logic       key_down,
  output logic       key_valid,
  output logic       key_rel,
  output logic       frame_err
);

  rx_byte_t   rx;
  dec_state_e state_q, state_d;
  logic [7:0] kbcode_q, kbcode_d;
  logic       is_ext_q, is_ext_d;
  logic       key_down_q, key_down_d;
  logic       key_valid_q, key_valid_d;
  logic       key_rel_q, key_rel_d;
  logic       make_c, make_ext_c, brk_c;

  ps2_keyboard_decoder_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .rx_o      (rx)
  );

  assign kbcode    = kbcode_q;
  assign is_ext    = is_ext_q;
  assign key_down  = key_down_q;
  assign key_valid = key_valid_q;
  assign key_rel   = key_rel_q;
  assign frame_err = rx.err;

  // Prefix tracking, then make/break resolution against the held code
  always_comb begin
    state_d     = state_q;
    kbcode_d    = kbcode_q;
    is_ext_d    = is_ext_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
    key_rel_d   = 1'b0;
    make_c      = 1'b0;
    make_ext_c  = 1'b0;
    brk_c       = 1'b0;
    if (rx.rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (rx.data == PS2_BREAK)    state_d = ST_BRK;
          else if (rx.data == PS2_EXT) state_d = ST_EXT;
          else                         make_c  = 1'b1;
        end
        ST_EXT: begin
          if (rx.data == PS2_BREAK)    state_d = ST_EXT_BRK;
          else if (rx.data == PS2_EXT) state_d = ST_EXT;
          else begin
            make_c     = 1'b1;
            make_ext_c = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          brk_c   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (make_c) begin
      kbcode_d   = rx.data;
      is_ext_d   = make_ext_c;
      key_down_d = 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
      key_valid_d = !(key_down_q && (rx.data == kbcode_q));
`else
      key_valid_d = 1'b1;
`endif
    end
    if (brk_c && (rx.data == kbcode_q) && ((state_q == ST_EXT_BRK) == is_ext_q)) begin
      key_down_d = 1'b0;
      key_rel_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      kbcode_q    <= '0;
      is_ext_q    <= 1'b0;
      key_down_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_rel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kbcode_q    <= kbcode_d;
      is_ext_q    <= is_ext_d;
      key_down_q  <= key_down_d;
      key_valid_q <= key_valid_d;
      key_rel_q   <= key_rel_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: byte-level key model plus directed literal checks.
module tb_ps2_keyboard_decoder;

  localparam int unsigned TO_CYC = 500;
  localparam int unsigned PS2_Q  = 20;  // quarter PS/2 bit period; one bit is 20 system clocks

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] kbcode;
  logic       is_ext, key_down, key_valid, key_rel, frame_err;

  always #2 clk = ~clk;

  ps2_keyboard_decoder #(.TIMEOUT_CYC(TO_CYC)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbcode   (kbcode),
    .is_ext   (is_ext),
    .key_down (key_down),
    .key_valid(key_valid),
    .key_rel  (key_rel),
    .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Key model: held code and flags, pending prefixes, expected strobe totals
  logic [7:0] m_kb;
  logic       m_ext, m_down, m_pend_ext, m_pend_brk;
  int         m_valid = 0, m_rel = 0, m_err = 0;
  int         n_valid = 0, n_rel = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kb = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_pend_ext = 1'b0; m_pend_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pend_brk) begin
      if (b == m_kb && m_pend_ext == m_ext && m_down) begin
        m_down = 1'b0;
        m_rel++;
      end else if (b == m_kb && m_pend_ext == m_ext) begin
        m_rel++;
      end
      m_pend_brk = 1'b0;
      m_pend_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_pend_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_pend_ext = 1'b1;
    end else begin
`ifdef PS2_REPEAT_FILTER_EN
      if (!(m_down && b == m_kb)) m_valid++;
`else
      m_valid++;
`endif
      m_kb = b; m_ext = m_pend_ext; m_down = 1'b1; m_pend_ext = 1'b0;
    end
  endtask

  // Strobe counting and per-cycle comparison against the model
  always @(negedge clk) begin
    if (key_valid === 1'b1) n_valid++;
    if (key_rel === 1'b1)   n_rel++;
    if (frame_err === 1'b1) n_err++;
    if (check_en) begin
      check("kbcode",    32'(kbcode),   32'(m_kb));
      check("is_ext",    32'(is_ext),   32'(m_ext));
      check("key_down",  32'(key_down), 32'(m_down));
      check("valid_cnt", 32'(n_valid),  32'(m_valid));
      check("rel_cnt",   32'(n_rel),    32'(m_rel));
      check("err_cnt",   32'(n_err),    32'(m_err));
      check("strobe_excl", 32'(key_valid & key_rel), 32'd0);
    end
  end

  task automatic ps2_bit(input logic v, input bit last);
    ps2_data = v;
    #(PS2_Q);
    if (last) check_en = 1'b0;
    ps2_clk = 1'b0;
    #(2 * PS2_Q);
    ps2_clk = 1'b1;
    #(PS2_Q);
  endtask

  // Drives nbits of a frame; a full frame updates the model once outputs have settled
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10);
    if (nbits == 11) begin
      if (bad_par) m_err++;
      else model_byte(b);
      check_en = 1'b1;
    end
    #(2 * PS2_Q);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  int v0, r0, e0;

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    #1;
    check("rst_kbcode", 32'(kbcode), 32'h0);
    check("rst_flags", 32'({is_ext, key_down, key_valid, key_rel, frame_err}), 32'h0);
    rst = 1'b0;
    check_en = 1'b1;
    #(4 * PS2_Q);

    // single make
    v0 = n_valid;
    send(8'h1C);
    check("t1_kbcode", 32'(kbcode), 32'h1C);
    check("t1_is_ext", 32'(is_ext), 32'h0);
    check("t1_down", 32'(key_down), 32'h1);
    check("t1_valid", 32'(n_valid - v0), 32'd1);

    // plain break of held key
    v0 = n_valid; r0 = n_rel;
    send(8'hF0); send(8'h1C);
    check("t2_rel", 32'(n_rel - r0), 32'd1);
    check("t2_down", 32'(key_down), 32'h0);
    check("t2_kbcode", 32'(kbcode), 32'h1C);
    check("t2_valid", 32'(n_valid - v0), 32'd0);

    // extended make then extended break
    v0 = n_valid; r0 = n_rel;
    send(8'hE0); send(8'h75);
    check("t3_kbcode", 32'(kbcode), 32'h75);
    check("t3_is_ext", 32'(is_ext), 32'h1);
    check("t3_valid", 32'(n_valid - v0), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t3_rel", 32'(n_rel - r0), 32'd1);
    check("t3_down", 32'(key_down), 32'h0);

    // plain break must not release an extended key
    r0 = n_rel;
    send(8'hE0); send(8'h75); send(8'hF0); send(8'h75);
    check("t3b_norel", 32'(n_rel - r0), 32'd0);
    check("t3b_down", 32'(key_down), 32'h1);
    send(8'hE0); send(8'hF0); send(8'h75);

    // parity error
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 11);
    check("t4_err", 32'(n_err - e0), 32'd1);
    check("t4_valid", 32'(n_valid - v0), 32'd0);
    check("t4_kbcode", 32'(kbcode), 32'h75);

    // stalled partial frame times out silently
    v0 = n_valid; e0 = n_err;
    send_frame(8'h5A, 1'b0, 5);
    #((TO_CYC + 200) * 4);
    send(8'h2D);
    check("t5_kbcode", 32'(kbcode), 32'h2D);
    check("t5_err", 32'(n_err - e0), 32'd0);
    check("t5_valid", 32'(n_valid - v0), 32'd1);

    // typematic repeats
    v0 = n_valid;
    send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
    check("t6_repeat", 32'(n_valid - v0), 32'd1);
`else
    check("t6_repeat", 32'(n_valid - v0), 32'd3);
`endif

    // reset mid-frame
    send_frame(8'h33, 1'b0, 4);
    check_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t7_rst_kbcode", 32'(kbcode), 32'h0);
    check("t7_rst_flags", 32'({is_ext, key_down, key_valid, key_rel, frame_err}), 32'h0);
    model_reset();
    rst = 1'b0;
    check_en = 1'b1;
    #(4 * PS2_Q);
    v0 = n_valid;
    send(8'h1C);
    check("t7_kbcode", 32'(kbcode), 32'h1C);
    check("t7_down", 32'(key_down), 32'h1);
    check("t7_valid", 32'(n_valid - v0), 32'd1);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
